// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout block.
//   - default 640x480@60 timing constants, scale factor and framebuffer pitch
//   - rgb444_t: packed r/g/b nibbles driven to the connector
//   - rgb332_to_rgb444: RGB332 framebuffer byte to 12-bit colour
package vga_pkg;

  localparam int CLK_DIV_DEF  = 4;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int SCALE_DEF    = 4;
  localparam int FB_WIDTH_DEF = 160;
  localparam logic [14:0] FB_BASE_DEF = 15'h0000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Top bits are replicated into the low bits so full-scale input gives 4'hF.
  function automatic rgb444_t rgb332_to_rgb444(input logic [7:0] d);
    rgb444_t c;
    c.r = {d[7:5], d[7]};
    c.g = {d[4:2], d[4]};
    c.b = {d[1:0], d[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider and raster counters.
//   clk, rst      : system clock, synchronous active-high reset
//   tick          : one-CLK strobe every CLK_DIV cycles; counters step on it
//   frame_end     : tick on the last pixel of the frame
//   active        : current (h,v) lies in the visible area
//   col_advance   : tick that moves to another visible pixel on the same line
//   row_advance   : tick that moves to the first pixel of the next visible line
//   hs_raw/vs_raw : active-low syncs decoded from the current counters
//   vblank_raw    : current line is in vertical blanking
//   vblank_start  : registered one-CLK pulse as v becomes V_ACTIVE
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic frame_end,
  output logic active,
  output logic col_advance,
  output logic row_advance,
  output logic hs_raw,
  output logic vs_raw,
  output logic vblank_raw,
  output logic vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          line_end;

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign line_end  = tick && (h == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v == VW'(V_TOTAL - 1));

  assign active      = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  // Stepping stops at the last visible pixel/line so the fetch address
  // freezes on its last value for the whole blanking interval.
  assign col_advance = tick && (h < HW'(H_ACTIVE - 1)) && (v < VW'(V_ACTIVE));
  assign row_advance = line_end && (v < VW'(V_ACTIVE - 1));

  assign hs_raw     = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw     = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign vblank_raw = (v >= VW'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      h            <= '0;
      v            <= '0;
      vblank_start <= 1'b0;
    end else begin
      // Registered on the same edge that moves v to V_ACTIVE, held one CLK.
      vblank_start <= line_end && (v == VW'(V_ACTIVE - 1));
      if (tick) begin
        div <= '0;
        if (line_end) begin
          h <= '0;
          v <= frame_end ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// Display refresh: walks VGA timing, fetches the RGB332 framebuffer through
// the video memory's asynchronous read port and upscales each byte SCALExSCALE.
//   CLK, RST          : system clock, synchronous active-high reset
//   VRAM_RDEN/ADDR    : read request to video memory port 1 (combinational)
//   VRAM_DATA         : byte returned in the same cycle
//   VGA_R/G/B         : registered 4-bit colour, zero outside the visible area
//   VGA_HS/VGA_VS     : registered active-low syncs
//   VBLANK            : registered vertical-blank level
//   VBLANK_START      : one-CLK pulse as the raster enters vertical blank
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SCALE    = SCALE_DEF,
  parameter int FB_WIDTH = FB_WIDTH_DEF,
  parameter logic [14:0] FB_BASE = FB_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        VRAM_RDEN,
  output logic [14:0] VRAM_ADDR,
  input  logic [7:0]  VRAM_DATA,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VBLANK,
  output logic        VBLANK_START
);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic          tick;
  logic          frame_end;
  logic          active;
  logic          col_advance;
  logic          row_advance;
  logic          hs_raw;
  logic          vs_raw;
  logic          vblank_raw;
  logic [SW-1:0] x_sub;
  logic [SW-1:0] y_sub;
  logic [14:0]   fb_x;
  logic [14:0]   row_base;
  rgb444_t       rgb;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (CLK),
    .rst          (RST),
    .tick         (tick),
    .frame_end    (frame_end),
    .active       (active),
    .col_advance  (col_advance),
    .row_advance  (row_advance),
    .hs_raw       (hs_raw),
    .vs_raw       (vs_raw),
    .vblank_raw   (vblank_raw),
    .vblank_start (VBLANK_START)
  );

  // Multiplier-free address walk: sub-counters divide h and v by SCALE,
  // row_base accumulates the pitch once per SCALE lines.
  always_ff @(posedge CLK) begin
    if (RST || frame_end) begin
      x_sub    <= '0;
      y_sub    <= '0;
      fb_x     <= '0;
      row_base <= '0;
    end else if (row_advance) begin
      x_sub <= '0;
      fb_x  <= '0;
      if (y_sub == SW'(SCALE - 1)) begin
        y_sub    <= '0;
        row_base <= row_base + 15'(FB_WIDTH);
      end else begin
        y_sub <= y_sub + 1'b1;
      end
    end else if (col_advance) begin
      if (x_sub == SW'(SCALE - 1)) begin
        x_sub <= '0;
        fb_x  <= fb_x + 1'b1;
      end else begin
        x_sub <= x_sub + 1'b1;
      end
    end
  end

  assign VRAM_ADDR = FB_BASE + row_base + fb_x;
  assign VRAM_RDEN = active && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rgb    <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VBLANK <= 1'b0;
    end else if (tick) begin
      rgb    <= active ? rgb332_to_rgb444(VRAM_DATA) : '0;
      VGA_HS <= hs_raw;
      VGA_VS <= vs_raw;
      VBLANK <= vblank_raw;
    end
  end

  assign VGA_R = rgb.r;
  assign VGA_G = rgb.g;
  assign VGA_B = rgb.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster (24x16 total, 16x12
// visible) so several frames and a mid-frame reset fit in a short run.
module tb_vga_scanout;

  localparam int CDIV = 4;
  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 12, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int SC = 4;
  localparam int FBW = 4;
  localparam logic [14:0] BASE = 15'h7FF8;
  localparam int FRAME_PIX = HT * VT;
  localparam int FRAME_CLK = FRAME_PIX * CDIV;
  localparam int VBS0 = VA * HT * CDIV;
  localparam int RST_AT = CDIV * (2 * FRAME_PIX + 5 * HT + 10) + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic        rden;
  } addr_exp_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } out_exp_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        vram_rden;
  logic [14:0] vram_addr;
  logic [7:0]  vram_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vblank, vblank_start;

  logic [7:0]  mem [0:32767];
  int          n = -1;
  int          checks = 0;
  int          failures = 0;
  logic [14:0] last_addr;
  addr_exp_t   aq[$];
  out_exp_t    oq[$];

  always #5 clk = ~clk;

  assign vram_data = mem[vram_addr];

  vga_scanout #(
    .CLK_DIV (CDIV),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SCALE   (SC),
    .FB_WIDTH(FBW),
    .FB_BASE (BASE)
  ) dut (
    .CLK         (clk),
    .RST         (RST),
    .VRAM_RDEN   (vram_rden),
    .VRAM_ADDR   (vram_addr),
    .VRAM_DATA   (vram_data),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VBLANK      (vblank),
    .VBLANK_START(vblank_start)
  );

  // CLK edges since reset was last sampled high.
  always @(posedge clk) begin
    if (RST) n <= 0;
    else if (n >= 0) n <= n + 1;
  end

  function automatic logic [11:0] expand(input logic [7:0] d);
    int r3, g3, b2;
    r3 = int'(d) / 32;
    g3 = (int'(d) / 4) % 8;
    b2 = int'(d) % 4;
    return 12'((r3 * 2 + r3 / 4) * 256 + (g3 * 2 + g3 / 4) * 16 + b2 * 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (clk %0d after reset)", name, act, exp, n);
    end
  endtask

  // Producer: for each pixel, derive the expected fetch and output from the
  // raster position by plain arithmetic, half a pixel before it is checked.
  initial begin : producer
    int p, h, v;
    logic act;
    logic [11:0] col;
    forever begin
      @(negedge clk);
      if (n == 0) begin
        last_addr = BASE;
      end else if (n >= 2 && (n % CDIV) == 2) begin
        p = ((n - 2) / CDIV) % FRAME_PIX;
        h = p % HT;
        v = p / HT;
        act = (h < HA) && (v < VA);
        if (act) last_addr = 15'(int'(BASE) + (v / SC) * FBW + h / SC);
        col = act ? expand(mem[last_addr]) : 12'h000;
        aq.push_back({last_addr, act});
        oq.push_back({col,
                      !((h >= HA + HFP) && (h < HA + HFP + HSY)),
                      !((v >= VA + VFP) && (v < VA + VFP + VSY)),
                      (v >= VA)});
      end
    end
  end

  // Monitor: on the last CLK of each pixel compare the fetch for that pixel
  // and the registered outputs of the previous pixel.
  initial begin : monitor
    addr_exp_t a;
    out_exp_t  o;
    logic      vbs_exp;
    forever begin
      @(negedge clk);
      if (n == 0) begin
        aq.delete();
        oq.delete();
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_vblank", 32'(vblank), 32'd0);
        check("rst_vblank_start", 32'(vblank_start), 32'd0);
        check("rst_rden", 32'(vram_rden), 32'(!RST));
      end else if (n >= 1) begin
        vbs_exp = (n >= VBS0) && (((n - VBS0) % FRAME_CLK) == 0);
        check("vblank_start", 32'(vblank_start), 32'(vbs_exp));
        if ((n % CDIV) == 3) begin
          if (aq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_addr: queue empty, got none required entry");
          end else begin
            a = aq.pop_front();
            check("rden", 32'(vram_rden), 32'(a.rden));
            check("addr", 32'(vram_addr), 32'(a.addr));
          end
          if (n >= 7) begin
            if (oq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sb_out: queue empty, got none required entry");
            end else begin
              o = oq.pop_front();
              check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(o.rgb));
              check("sync_vblank", 32'({vga_hs, vga_vs, vblank}), 32'({o.hs, o.vs, o.vb}));
            end
          end
        end
      end
    end
  end

  // One CLK of stimulus; mid-pixel random writes to the framebuffer region
  // after the first frame, visible to the very next fetch.
  task automatic step();
    logic [14:0] wa;
    @(negedge clk);
    #1;
    if (n > FRAME_CLK && (n % CDIV) == 1 && $urandom_range(0, 2) == 0) begin
      wa = BASE + 15'($urandom_range(0, (VA / SC) * FBW - 1));
      mem[wa] = 8'($urandom);
    end
  endtask

  initial begin
    RST = 1'b1;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[BASE] = 8'hE3;
    mem[BASE + 15'd1] = 8'h1C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 RST = 1'b0;
    for (int c = 0; c < RST_AT + 16 && n != RST_AT; c++) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (2 * FRAME_CLK + 64) step();
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
